// File: rtl/instr_issue_unit.sv
// Fetch/issue sequencer feeding opCode/fCode to the controller: owns the PC,
// reads a synchronous instruction memory and issues one instruction per 3 cycles.
module instr_issue_unit #(
  parameter int               ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic [3:0]        opCode,
  output logic [3:0]        fCode,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, LATCH, ISSUE, HALT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;

  assign pc_plus1 = pc_q + ADDR_W'(1);

  // Branch inputs only matter on the cycle ISSUE is left; a halt overrides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state_q)
        FETCH: state_q <= LATCH;
        LATCH: begin
          instr_q <= imem_rdata;
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (!stall) begin
            if (instr_q[31:28] == HALT_OP) begin
              state_q <= HALT;
            end else if (branch_taken) begin
              pc_q    <= branch_target;
              state_q <= FETCH;
            end else begin
              pc_q    <= pc_plus1;
              state_q <= FETCH;
            end
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_rd_en  = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opCode      = instr_q[31:28];
  assign fCode       = instr_q[27:24];
  assign pc          = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign halted      = (state_q == HALT);

endmodule
